wb_mem_slave: RTL
=================

# wb_mem_slave

Wishbone classic single-cycle slave wrapping a synchronous word-wide RAM. It sits on a slave port of the Wishbone interconnect (e.g. the `mem_wbs_*` port) and answers read/write cycles issued by any granted master. The wait-state count is configurable so bus timing can be stretched to match the target memory. The interconnect has already decoded the base address; this block only uses the low address bits.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of `wbs_address`.
- DATA_WIDTH, 32, width of data buses and RAM words.
- MEM_ADDR_WIDTH, 8, RAM index width; depth is 2^MEM_ADDR_WIDTH words.
- WAIT_STATES, 1, extra cycles before ack; legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wbs_address  in  ADDR_WIDTH  word address; only bits [MEM_ADDR_WIDTH-1:0] are used.
- wbs_writedata  in  DATA_WIDTH  write data.
- wbs_readdata  out  DATA_WIDTH  read data; valid while `wbs_ack` is 1.
- wbs_strobe  in  1  transfer request.
- wbs_cycle  in  1  bus cycle active.
- wbs_write  in  1  1 = write, 0 = read.
- wbs_ack  out  1  registered transfer acknowledge; one-cycle pulse.

## Operation
- Request: `wbs_cycle & wbs_strobe` is 1 at a rising edge.
- RAM index: `wbs_address[MEM_ADDR_WIDTH-1:0]`. Upper bits are ignored, so the RAM aliases across the address space.
- State machine states:
  - IDLE: ack is 0. On a request:
    - WAIT_STATES = 0: go to ACK and perform the access.
    - WAIT_STATES > 0: load the 4-bit counter with WAIT_STATES-1 and go to WAIT.
  - WAIT:
    - Request dropped: go to IDLE (abort). No access, no ack.
    - Counter = 0: go to ACK and perform the access.
    - Otherwise: decrement the counter and stay in WAIT.
  - ACK: ack is 1. Always returns to IDLE on the next edge; requests are not sampled here.
- Access, performed on the edge that enters ACK:
  - Write: RAM[index] <= `wbs_writedata`.
  - Read: `wbs_readdata` <= RAM[index], using the address present at that edge.
  - `wbs_write` is sampled at that same edge.
- `wbs_readdata` holds its last read value. Writes do not change it.
- RAM contents are not cleared by reset. Reading an unwritten location returns an undefined value.

## Timing
- Reset values: `wbs_ack` = 0, `wbs_readdata` = 0, state = IDLE, counter = 0.
- Reset at any point, including in WAIT or ACK:
  - Forces IDLE on that edge.
  - Suppresses any RAM write on that edge.
  - Suppresses any ack.
- Request first sampled at edge T0:
  - `wbs_ack` rises after edge T0+WAIT_STATES and falls after edge T0+WAIT_STATES+1.
  - Read data is valid during the same cycle as the ack.
- Master holds the request through ack:
  - The ACK→IDLE edge ignores the request, which prevents a double ack.
  - The earliest next sample is edge T0+WAIT_STATES+2.
  - Throughput is one transfer per WAIT_STATES+2 cycles.
- Abort: the request is dropped before the edge that would enter ACK. No RAM write occurs and no ack is produced.
- Changes to address or data during WAIT are legal; the values at the access edge are used.

## Test plan
- Reset: assert `reset` for 2 cycles with `wbs_strobe` = `wbs_cycle` = 1. Required: `wbs_ack` stays 0 and `wbs_readdata` = 0x00000000 throughout and on the first cycle after release.
- Write then read, WAIT_STATES = 1:
  - Write 0xDEADBEEF to address 0x05, request sampled at T0. Required: ack high only in the cycle after edge T0+1.
  - Read address 0x05. Required: ack one cycle wide, `wbs_readdata` = 0xDEADBEEF during ack.
- Back-to-back, WAIT_STATES = 0: hold `cycle`/`strobe` high for two reads of 0x01 and 0x02 (pre-loaded with 0x11 and 0x22). Required:
  - Acks after T0 and T0+2.
  - ack = 0 after T0+1.
  - Read data 0x11, then 0x22.
- Abort, WAIT_STATES = 3: address 0x07 holds 0xAAAA0000. Start a write of 0x12345678 to 0x07 and drop `wbs_strobe` after 2 cycles. Required: no ack, and a later read of 0x07 returns 0xAAAA0000.
- Aliasing, MEM_ADDR_WIDTH = 8: write 0xCAFEF00D to address 0x00000105. Required: a read of 0x05 returns 0xCAFEF00D.
- Reset mid-transfer, WAIT_STATES = 2: address 0x09 holds 0x0. Start a write of 0xFFFFFFFF to 0x09 and pulse `reset` on the edge that would enter ACK. Required: no ack, and a subsequent read of 0x09 returns 0x0.

Source files
------------

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave in front of a synchronous word-wide RAM.
// A configurable number of wait states is inserted before each one-cycle ack.
module wb_mem_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int WAIT_STATES    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    input  logic                  wbs_write,
    output logic                  wbs_ack
);

    localparam int       MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam bit       NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                      state_reg;
    logic [3:0]                  count_reg;
    logic                        ack_reg;
    logic [DATA_WIDTH-1:0]       readdata_reg;
    logic [DATA_WIDTH-1:0]       mem [0:MEM_DEPTH-1];

    logic                        request;
    logic [MEM_ADDR_WIDTH-1:0]   mem_index;
    logic                        enter_ack;

    assign request   = wbs_cycle & wbs_strobe;
    assign mem_index = wbs_address[MEM_ADDR_WIDTH-1:0];

    // The access happens on exactly the edge that moves the FSM into ACK.
    always_comb begin
        enter_ack = 1'b0;
        if (request) begin
            if (state_reg == ST_IDLE && NO_WAIT)
                enter_ack = 1'b1;
            else if (state_reg == ST_WAIT && count_reg == 4'd0)
                enter_ack = 1'b1;
        end
    end

    // Upper address bits only alias the RAM; fold them into a sink.
    generate
        if (ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_addr_sink
            logic unused_addr_bits;
            assign unused_addr_bits = ^wbs_address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
        end
    endgenerate

    // RAM array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && enter_ack && wbs_write)
            mem[mem_index] <= wbs_writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 4'd0;
            ack_reg      <= 1'b0;
            readdata_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            if (enter_ack && !wbs_write)
                readdata_reg <= mem[mem_index];
            case (state_reg)
                ST_IDLE: begin
                    if (request) begin
                        if (NO_WAIT) begin
                            state_reg <= ST_ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                            count_reg <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!request) begin
                        state_reg <= ST_IDLE;
                        count_reg <= 4'd0;
                    end else if (count_reg == 4'd0) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                ST_ACK: begin
                    // Request is deliberately not sampled here to avoid a double ack.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= 4'd0;
                end
            endcase
        end
    end

    assign wbs_ack      = ack_reg;
    assign wbs_readdata = readdata_reg;

endmodule
